// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The branch-target constants are regenerated by the assembler flow.
package fetch_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned COUNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam logic [INSTR_W-1:0] HALT_INSTR_DEFAULT = 9'h1FF;

  localparam int unsigned BT0 = 0;
  localparam int unsigned BT1 = 16;
  localparam int unsigned BT2 = 32;
  localparam int unsigned BT3 = 48;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // Saturating increment: the cycle counter sticks at all-ones.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (value == COUNT_MAX) ? value : value + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: launch control, ROM word, decoder feedback and fetch outputs.
// master is the fetch unit; slave is the surrounding ROM/decoder/testbench.
interface fetch_if #(
  parameter int PCW = 10
);
  import fetch_pkg::*;

  logic                 start;
  logic [INSTR_W-1:0]   instr_in;
  logic                 branch;
  logic [1:0]           how_high;
  logic [PCW-1:0]       pc_out;
  logic [INSTR_W-1:0]   instr_out;
  logic                 exec_en;
  logic                 done;
  logic [COUNT_W-1:0]   cycle_count;

  modport master (
    input  start, instr_in, branch, how_high,
    output pc_out, instr_out, exec_en, done, cycle_count
  );

  modport slave (
    output start, instr_in, branch, how_high,
    input  pc_out, instr_out, exec_en, done, cycle_count
  );

endinterface

// File: rtl/branch_lut.sv
// Combinational 4-entry branch-target ROM: how_high selects an absolute PC.
// Kept as its own module so the assembler flow can regenerate the contents.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PCW = 10
) (
  input  logic [1:0]     how_high,
  output logic [PCW-1:0] target
);

  always_comb begin
    // NOTE: default first so every path assigns target and no latch is inferred.
    target = '0;
    unique case (how_high)
      2'd0: target = PCW'(BT0);
      2'd1: target = PCW'(BT1);
      2'd2: target = PCW'(BT2);
      2'd3: target = PCW'(BT3);
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, start/run/done sequencer, halt detect
// and saturating RUN-cycle counter. The instruction ROM lives outside.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 PCW        = 10,
  parameter int                 PROG_LEN   = 1024,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.master bus
);

  localparam logic [PCW-1:0] LAST_PC = PCW'(PROG_LEN - 1);

  fetch_state_t        state;
  logic [PCW-1:0]      pc;
  logic                done_q;
  logic [COUNT_W-1:0]  count;

  logic [PCW-1:0]      bt_target;
  logic                is_halt;
  logic                at_last;

  branch_lut #(
    .PCW (PCW)
  ) u_branch_lut (
    .how_high (bus.how_high),
    .target   (bt_target)
  );

  assign is_halt = (bus.instr_in == HALT_INSTR);
  assign at_last = (pc == LAST_PC);

  assign bus.pc_out      = pc;
  assign bus.instr_out   = bus.instr_in;
  assign bus.exec_en     = (state == RUN) && !is_halt;
  assign bus.done        = done_q;
  assign bus.cycle_count = count;

  // Halt word outranks a branch; a taken branch outranks end-of-program.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from values sampled before the edge.
      state  <= IDLE;
      pc     <= '0;
      done_q <= 1'b0;
      count  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= RUN;
            pc     <= '0;
            count  <= '0;
            done_q <= 1'b0;
          end
        end
        RUN: begin
          count <= sat_inc(count);
          if (is_halt) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else if (bus.branch) begin
            pc <= bt_target;
          end else if (at_last) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            pc <= pc + PCW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
